// File: rtl/rv_multicycle_ctrl_if.sv
// Control/status bundle between the RV32I multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface rv_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        alu_lt;
  logic        mem_ready;
  logic        pc_we;
  logic        pc_src;
  logic        ir_we;
  logic [2:0]  imm_sel;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [2:0]  state_o;

  modport master (
    input  instr, alu_zero, alu_lt, mem_ready,
    output pc_we, pc_src, ir_we, imm_sel, alu_src_a, alu_src_b, alu_op,
           mem_req, mem_we, mem_addr_sel, reg_we, wb_sel,
           trap, trap_cause, instret, state_o
  );

  modport slave (
    output instr, alu_zero, alu_lt, mem_ready,
    input  pc_we, pc_src, ir_we, imm_sel, alu_src_a, alu_src_b, alu_op,
           mem_req, mem_we, mem_addr_sel, reg_we, wb_sel,
           trap, trap_cause, instret, state_o
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing with
// a memory handshake timeout, sticky trap state and retired-instruction counter.
module rv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rv_multicycle_ctrl_if.master bus
);
  localparam int unsigned TMO_W = 8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPI    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_NONE = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] CAUSE_ILL = 2'd1, CAUSE_TMO = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       is_op, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, legal;
  logic       unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7b5     = bus.instr[30];
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  assign is_op   = (opcode == OPC_OP);
  assign is_opi  = (opcode == OPC_OPI);
  assign is_ld   = (opcode == OPC_LOAD);
  assign is_st   = (opcode == OPC_STORE);
  assign is_br   = (opcode == OPC_BRANCH);
  assign is_jal  = (opcode == OPC_JAL);
  assign is_jalr = (opcode == OPC_JALR);
  assign legal   = is_op | is_opi | is_ld | is_st | is_br | is_jal | is_jalr;

  // Operand/immediate setup implied by the latched instruction
  logic [2:0] dec_imm;
  logic       dec_src_a, dec_src_b;
  logic [3:0] dec_op, f3_op;

  always_comb begin
    dec_imm   = IMM_NONE;
    dec_src_a = 1'b0;
    dec_src_b = 1'b0;
    dec_op    = ALU_ADD;
    case (funct3)
      3'd0:    f3_op = ALU_ADD;
      3'd1:    f3_op = ALU_SLL;
      3'd2:    f3_op = ALU_SLT;
      3'd3:    f3_op = ALU_SLTU;
      3'd4:    f3_op = ALU_XOR;
      3'd5:    f3_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
    if (is_op) begin
      dec_op = (funct3 == 3'd0 && funct7b5) ? ALU_SUB : f3_op;
    end else if (is_opi) begin
      dec_imm   = IMM_I;
      dec_src_b = 1'b1;
      dec_op    = f3_op;
    end else if (is_ld || is_jalr) begin
      dec_imm   = IMM_I;
      dec_src_b = 1'b1;
    end else if (is_st) begin
      dec_imm   = IMM_S;
      dec_src_b = 1'b1;
    end else if (is_br) begin
      dec_imm = IMM_B;
      dec_op  = ALU_SUB;
    end else if (is_jal) begin
      dec_imm   = IMM_J;
      dec_src_a = 1'b1;
      dec_src_b = 1'b1;
    end
  end

  logic br_ok, br_taken, tmo_hit;

  always_comb begin
    br_ok    = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'd0:    br_taken = bus.alu_zero;
      3'd1:    br_taken = !bus.alu_zero;
      3'd4:    br_taken = bus.alu_lt;
      3'd5:    br_taken = !bus.alu_lt;
      default: br_ok    = 1'b0;
    endcase
  end

  // Limit reached on this waiting cycle; a same-cycle mem_ready takes priority
  assign tmo_hit = ((9'(tmo_q) + 9'd1) >= 9'(MEM_TIMEOUT));

  logic       pc_we_c, pc_src_c, ir_we_c, src_a_c, src_b_c;
  logic       mem_req_c, mem_we_c, mem_addr_sel_c, reg_we_c, retire_c;
  logic [2:0] imm_sel_c;
  logic [3:0] alu_op_c;
  logic [1:0] wb_sel_c;

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    trap_d         = trap_q;
    cause_d        = cause_q;
    instret_d      = instret_q;
    pc_we_c        = 1'b0;
    pc_src_c       = 1'b0;
    ir_we_c        = 1'b0;
    imm_sel_c      = IMM_NONE;
    src_a_c        = 1'b0;
    src_b_c        = 1'b0;
    alu_op_c       = ALU_ADD;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    reg_we_c       = 1'b0;
    wb_sel_c       = WB_ALU;
    retire_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        if (is_op || is_opi) begin
          state_d = S_WB;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_br && br_ok) begin
          pc_we_c  = 1'b1;
          pc_src_c = br_taken;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jal || is_jalr) begin
          pc_we_c  = 1'b1;
          pc_src_c = 1'b1;
          reg_we_c = 1'b1;
          wb_sel_c = WB_PC4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = is_st;
        if (bus.mem_ready) begin
          if (is_st) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = is_ld ? WB_MEM : WB_ALU;
        pc_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase

    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      imm_sel_c = dec_imm;
      src_a_c   = dec_src_a;
      src_b_c   = dec_src_b;
      alu_op_c  = dec_op;
    end

    if (state_d == S_TRAP) trap_d = 1'b1;
    if (retire_c) instret_d = instret_q + 32'd1;

    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
      tmo_d = '0;
    end else if (mem_req_c && !bus.mem_ready) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    // Strobes are held low while reset is asserted
    if (rst) begin
      pc_we_c        = 1'b0;
      pc_src_c       = 1'b0;
      ir_we_c        = 1'b0;
      imm_sel_c      = IMM_NONE;
      src_a_c        = 1'b0;
      src_b_c        = 1'b0;
      alu_op_c       = ALU_ADD;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      reg_we_c       = 1'b0;
      wb_sel_c       = WB_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign bus.pc_we        = pc_we_c;
  assign bus.pc_src       = pc_src_c;
  assign bus.ir_we        = ir_we_c;
  assign bus.imm_sel      = imm_sel_c;
  assign bus.alu_src_a    = src_a_c;
  assign bus.alu_src_b    = src_b_c;
  assign bus.alu_op       = alu_op_c;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_addr_sel = mem_addr_sel_c;
  assign bus.reg_we       = reg_we_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.trap         = trap_q;
  assign bus.trap_cause   = cause_q;
  assign bus.instret      = instret_q;
  assign bus.state_o      = state_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: directed instructions expanded by a sequence model
// into per-cycle expected outputs, compared every cycle, plus literal spot checks.
module tb_rv_multicycle_ctrl;
  localparam int unsigned TMO = 4;

  logic clk, rst;
  rv_multicycle_ctrl_if bus();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_OP, K_OPI, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ILL} kind_e;

  typedef struct {
    logic        rst, chk, mr, az, alt;
    logic [31:0] instr;
    logic [2:0]  st;
    logic        pc_we, pc_src, ir_we;
    logic [2:0]  imm;
    logic        sa, sb;
    logic [3:0]  op;
    logic        mreq, mwe, mas, rwe;
    logic [1:0]  wb;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] icnt;
  } rec_t;

  // ALU operation chosen by funct3 when no funct7 modifier applies
  localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  rec_t        q[$];
  rec_t        cur;
  logic        en;
  int          n_run, n_fail, step;
  logic [31:0] m_ret;
  logic [55:0] act_v, exp_v;

  function automatic kind_e kind_of(input logic [31:0] i);
    case (i[6:0])
      7'h33:   return K_OP;
      7'h13:   return K_OPI;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input kind_e k);
    case (k)
      K_OPI, K_LD, K_JALR: return 3'd0;
      K_ST:                return 3'd1;
      K_BR:                return 3'd2;
      K_JAL:               return 3'd3;
      default:             return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] op_of(input logic [31:0] i, input kind_e k);
    logic [2:0] f3;
    f3 = i[14:12];
    case (k)
      K_OP: begin
        if (f3 == 3'd0 && i[30]) return 4'd1;
        if (f3 == 3'd5 && i[30]) return 4'd7;
        return F3_OP[f3];
      end
      K_OPI: begin
        if (f3 == 3'd5 && i[30]) return 4'd7;
        return F3_OP[f3];
      end
      K_BR:    return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic rec_t mk(input logic [31:0] i, input logic mr, input logic az,
                              input logic alt, input logic [2:0] st);
    rec_t  r;
    kind_e k;
    k       = kind_of(i);
    r       = '{default: '0};
    r.chk   = 1'b1;
    r.instr = i;
    r.mr    = mr;
    r.az    = az;
    r.alt   = alt;
    r.st    = st;
    r.imm   = 3'd4;
    r.icnt  = m_ret;
    if (st >= 3'd1 && st <= 3'd4) begin
      r.imm = imm_of(k);
      r.sa  = (k == K_JAL);
      r.sb  = (k == K_OPI || k == K_LD || k == K_ST || k == K_JAL || k == K_JALR);
      r.op  = op_of(i, k);
    end
    return r;
  endfunction

  task automatic add_trap(input logic [31:0] i, input logic [1:0] cause);
    rec_t r;
    for (int c = 0; c < 3; c++) begin
      r       = mk(i, 1'b1, 1'b0, 1'b0, 3'd7);
      r.trap  = 1'b1;
      r.cause = cause;
      q.push_back(r);
    end
  endtask

  task automatic add_reset(input int n);
    rec_t r;
    m_ret = 32'd0;
    r     = mk(32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    r.rst = 1'b1;
    r.chk = 1'b0;
    q.push_back(r);
    for (int c = 1; c < n; c++) begin
      r.chk = 1'b1;
      q.push_back(r);
    end
  endtask

  // Expand one instruction into its expected cycle sequence given the wait schedule
  task automatic add_instr(input logic [31:0] i, input logic az, input logic alt,
                           input int fw, input int mw);
    rec_t  r;
    kind_e k;
    logic  tk;
    k = kind_of(i);
    for (int c = 0; c < fw; c++) begin
      r = mk(i, 1'b0, az, alt, 3'd0);
      r.mreq = 1'b1;
      q.push_back(r);
      if (c + 1 == int'(TMO)) begin
        add_trap(i, 2'd2);
        return;
      end
    end
    r = mk(i, 1'b1, az, alt, 3'd0);
    r.mreq  = 1'b1;
    r.ir_we = 1'b1;
    q.push_back(r);
    q.push_back(mk(i, 1'b1, az, alt, 3'd1));
    if (k == K_ILL) begin
      add_trap(i, 2'd1);
      return;
    end
    r = mk(i, 1'b1, az, alt, 3'd2);
    if (k == K_BR) begin
      case (i[14:12])
        3'd0: tk = az;
        3'd1: tk = !az;
        3'd4: tk = alt;
        3'd5: tk = !alt;
        default: begin
          q.push_back(r);
          add_trap(i, 2'd1);
          return;
        end
      endcase
      r.pc_we  = 1'b1;
      r.pc_src = tk;
      q.push_back(r);
      m_ret++;
      return;
    end
    if (k == K_JAL || k == K_JALR) begin
      r.pc_we  = 1'b1;
      r.pc_src = 1'b1;
      r.rwe    = 1'b1;
      r.wb     = 2'd2;
      q.push_back(r);
      m_ret++;
      return;
    end
    q.push_back(r);
    if (k == K_LD || k == K_ST) begin
      for (int c = 0; c <= mw; c++) begin
        r = mk(i, (c == mw), az, alt, 3'd3);
        r.mreq = 1'b1;
        r.mas  = 1'b1;
        r.mwe  = (k == K_ST);
        if (c == mw && k == K_ST) r.pc_we = 1'b1;
        q.push_back(r);
        if (c < mw && c + 1 == int'(TMO)) begin
          add_trap(i, 2'd2);
          return;
        end
      end
      if (k == K_ST) begin
        m_ret++;
        return;
      end
    end
    r = mk(i, 1'b1, az, alt, 3'd4);
    r.rwe   = 1'b1;
    r.wb    = (k == K_LD) ? 2'd1 : 2'd0;
    r.pc_we = 1'b1;
    q.push_back(r);
    m_ret++;
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      cur           = q.pop_front();
      rst           = cur.rst;
      bus.instr     = cur.instr;
      bus.mem_ready = cur.mr;
      bus.alu_zero  = cur.az;
      bus.alu_lt    = cur.alt;
      en            = 1'b1;
      @(posedge clk);
      #1;
      step++;
    end
    en = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en && cur.chk) begin
      act_v = {bus.state_o, bus.pc_we, bus.pc_src, bus.ir_we, bus.imm_sel, bus.alu_src_a,
               bus.alu_src_b, bus.alu_op, bus.mem_req, bus.mem_we, bus.mem_addr_sel,
               bus.reg_we, bus.wb_sel, bus.trap, bus.trap_cause, bus.instret};
      exp_v = {cur.st, cur.pc_we, cur.pc_src, cur.ir_we, cur.imm, cur.sa, cur.sb, cur.op,
               cur.mreq, cur.mwe, cur.mas, cur.rwe, cur.wb, cur.trap, cur.cause, cur.icnt};
      n_run++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL ctrl_outputs step %0d instr %h: got state=%0d vec=%h, expected state=%0d vec=%h",
                 step, cur.instr, bus.state_o, act_v, cur.st, exp_v);
      end
    end
  end

  initial begin
    en = 1'b0; n_run = 0; n_fail = 0; step = 0; m_ret = 32'd0;
    rst = 1'b1; bus.instr = 32'd0; bus.mem_ready = 1'b1; bus.alu_zero = 1'b0; bus.alu_lt = 1'b0;

    add_reset(3);
    add_instr(32'h00500093, 1'b0, 1'b0, 0, 0);
    lit("addi_seq_len", 32'(q.size()), 32'd7);
    run_q();
    lit("addi_instret", bus.instret, 32'd1);

    add_instr(32'h0000A103, 1'b0, 1'b0, 0, 3);
    lit("load_wait_len", 32'(q.size()), 32'd8);
    run_q();

    add_instr(32'h00208463, 1'b1, 1'b0, 0, 0);
    lit("beq_len", 32'(q.size()), 32'd3);
    add_instr(32'h00208463, 1'b0, 1'b0, 0, 0);
    add_instr(32'h008000EF, 1'b0, 1'b0, 0, 0);
    run_q();
    lit("jal_instret", bus.instret, 32'd5);

    add_instr(32'h000080E7, 1'b0, 1'b0, 0, 0);
    add_instr(32'h0020A223, 1'b0, 1'b0, 1, 0);
    add_instr(32'h40208033, 1'b0, 1'b0, 0, 0);
    add_instr(32'h4020D0B3, 1'b0, 1'b0, 0, 0);
    add_instr(32'h4010D093, 1'b0, 1'b0, 0, 0);
    add_instr(32'h40000093, 1'b0, 1'b0, 0, 0);
    add_instr(32'h0020C463, 1'b0, 1'b1, 0, 0);
    add_instr(32'h0020D463, 1'b0, 1'b1, 0, 0);
    lit("mix_seq_len", 32'(q.size()), 32'd30);
    run_q();
    lit("mix_instret", bus.instret, 32'd13);

    add_instr(32'h0000007F, 1'b0, 1'b0, 0, 0);
    run_q();
    lit("illegal_trap", 32'(bus.trap), 32'd1);
    lit("illegal_cause", 32'(bus.trap_cause), 32'd1);
    lit("illegal_state", 32'(bus.state_o), 32'd7);
    add_reset(2);
    run_q();
    lit("reset_instret", bus.instret, 32'd0);
    lit("reset_trap", 32'(bus.trap), 32'd0);

    add_instr(32'h00500093, 1'b0, 1'b0, 4, 0);
    lit("fetch_tmo_len", 32'(q.size()), 32'd7);
    run_q();
    lit("fetch_tmo_cause", 32'(bus.trap_cause), 32'd2);
    add_reset(2);
    add_instr(32'h00500093, 1'b0, 1'b0, 3, 0);
    run_q();
    lit("ready_at_limit_trap", 32'(bus.trap), 32'd0);
    lit("ready_at_limit_instret", bus.instret, 32'd1);

    add_instr(32'h0020A463, 1'b0, 1'b0, 0, 0);
    run_q();
    lit("bad_branch_cause", 32'(bus.trap_cause), 32'd1);
    add_reset(2);
    add_instr(32'h0020A223, 1'b0, 1'b0, 0, 4);
    run_q();
    lit("store_tmo_cause", 32'(bus.trap_cause), 32'd2);
    lit("store_tmo_instret", bus.instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
